// File: rtl/mod_n_job_scheduler_pkg.sv
// Shared definitions for the mod-N job scheduler: FSM encoding,
// requester identifiers and a parameter-checking helper.
package mod_n_job_scheduler_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Requester identifiers as carried on grant/done id outputs.
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Ceiling log2, used to confirm that N fits in WIDTH bits.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_n_job_scheduler_step.sv
// mod_n_step_counter: shared mod-N up/down counter, advanced one
// position per cycle when i_step is high. Owns the wrap arithmetic.
module mod_n_step_counter #(
    parameter int WIDTH = 3,
    parameter int N     = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_step,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_q
);
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(N - 1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next value: wrap N-1 -> 0 going up, 0 -> N-1 going down.
    always_comb begin
        q_d = q_q;
        if (i_step) begin
            if (i_up) begin
                q_d = (q_q == Q_MAX) ? '0 : q_q + WIDTH'(1);
            end else begin
                q_d = (q_q == '0) ? Q_MAX : q_q - WIDTH'(1);
            end
        end
    end

    // Counter register; only reset clears it, so it holds between jobs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign o_q = q_q;

endmodule

// File: rtl/mod_n_job_scheduler.sv
// mod_n_job_scheduler: round-robin arbitration of two requesters onto
// one shared mod-N counter. Each job steps the counter len times.
//
// Handshake: a job is accepted on a rising edge where o_reqX_ready and
// i_reqX_valid are both high; ready is only ever offered in IDLE, to the
// single selected requester, and never while i_rst is high. Request
// fields are sampled at that edge only.
module mod_n_job_scheduler
    import mod_n_job_scheduler_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int N     = 6,
    parameter int LEN_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    input  logic             i_req0_up,
    input  logic [LEN_W-1:0] i_req0_len,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic             i_req1_up,
    input  logic [LEN_W-1:0] i_req1_len,
    output logic             o_req1_ready,
    input  logic             i_hold,
    output logic [WIDTH-1:0] o_Q,
    output logic             o_busy,
    output logic             o_grant_id,
    output logic             o_done,
    output logic             o_done_id,
    output state_t           o_state
);
    if (N < 2 || clog2(N) > WIDTH) begin : g_param_check
        $error("mod_n_job_scheduler: requires 2 <= N <= 2**WIDTH");
    end

    state_t           state_q;
    logic             rr_ptr_q;
    logic             grant_q;
    logic             dir_q;
    logic             busy_q;
    logic             done_q;
    logic             done_id_q;
    logic [LEN_W-1:0] remaining_q;

    logic             sel;
    logic             sel_up;
    logic [LEN_W-1:0] sel_len;
    logic             accept;
    logic             step;

    // Arbitration and combinational ready: rr_ptr breaks ties.
    always_comb begin
        if (i_req0_valid && i_req1_valid) begin
            sel = rr_ptr_q;
        end else if (i_req1_valid) begin
            sel = REQ1;
        end else begin
            sel = REQ0;
        end
        sel_up       = (sel == REQ1) ? i_req1_up  : i_req0_up;
        sel_len      = (sel == REQ1) ? i_req1_len : i_req0_len;
        accept       = (state_q == IDLE) && !i_rst && (i_req0_valid || i_req1_valid);
        o_req0_ready = accept && (sel == REQ0);
        o_req1_ready = accept && (sel == REQ1);
    end

    assign step = (state_q == RUN) && !i_hold;

    mod_n_step_counter #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_counter (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_step (step),
        .i_up   (dir_q),
        .o_q    (o_Q)
    );

    // Scheduler FSM with registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= REQ0;
            grant_q     <= REQ0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= REQ0;
            remaining_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        grant_q     <= sel;
                        dir_q       <= sel_up;
                        remaining_q <= sel_len;
                        busy_q      <= 1'b1;
                        if (sel_len == '0) begin
                            // Zero-length job completes without touching the counter.
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            done_id_q <= sel;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!i_hold) begin
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            done_id_q <= grant_q;
                        end
                    end
                end
                DONE: begin
                    rr_ptr_q <= ~grant_q;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_grant_id = grant_q;
    assign o_done     = done_q;
    assign o_done_id  = done_id_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_mod_n_job_scheduler.sv
// Testbench for mod_n_job_scheduler: directed and random jobs checked
// against a job-level reference model (modular arithmetic + round-robin).
module tb_mod_n_job_scheduler;
    import mod_n_job_scheduler_pkg::*;

    localparam int WIDTH = 3;
    localparam int N     = 6;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0;
    logic             req0_up = 1'b0;
    logic [LEN_W-1:0] req0_len = '0;
    logic             rdy0;
    logic             req1_valid = 1'b0;
    logic             req1_up = 1'b0;
    logic [LEN_W-1:0] req1_len = '0;
    logic             rdy1;
    logic             hold = 1'b0;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             grant;
    logic             done;
    logic             done_id;
    state_t           state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: counter value and round-robin pointer.
    int m_q  = 0;
    int m_rr = 0;

    mod_n_job_scheduler #(
        .WIDTH (WIDTH),
        .N     (N),
        .LEN_W (LEN_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (req0_valid),
        .i_req0_up    (req0_up),
        .i_req0_len   (req0_len),
        .o_req0_ready (rdy0),
        .i_req1_valid (req1_valid),
        .i_req1_up    (req1_up),
        .i_req1_len   (req1_len),
        .o_req1_ready (rdy1),
        .i_hold       (hold),
        .o_Q          (q),
        .o_busy       (busy),
        .o_grant_id   (grant),
        .o_done       (done),
        .o_done_id    (done_id),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int mod_step(input int v, input bit up);
        return up ? (v + 1) % N : (v + N - 1) % N;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; applies reset with both requesters asking.
    task automatic do_reset(input int cycles);
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        hold = 1'b0;
        #1;
        chk("rst_ready0", rdy0, 0);
        chk("rst_ready1", rdy1, 0);
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        m_q  = 0;
        m_rr = 0;
        chk("rst_q", q, 0);
        chk("rst_state", state, IDLE);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_grant", grant, 0);
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling
    // edge of the first IDLE cycle after DONE, valids still asserted.
    task automatic do_job(input bit v0, input bit up0, input int len0,
                          input bit v1, input bit up1, input int len1,
                          input int hold_at, input int hold_n);
        int sel;
        bit up;
        int len;
        sel = (v0 && v1) ? m_rr : (v1 ? 1 : 0);
        up  = (sel == 1) ? up1 : up0;
        len = (sel == 1) ? len1 : len0;
        req0_valid = v0;
        req0_up    = up0;
        req0_len   = LEN_W'(len0);
        req1_valid = v1;
        req1_up    = up1;
        req1_len   = LEN_W'(len1);
        #1;
        chk("idle_ready0", rdy0, (v0 && sel == 0) ? 1 : 0);
        chk("idle_ready1", rdy1, (v1 && sel == 1) ? 1 : 0);
        @(posedge clk);
        #1;
        // Fields changed after accept must not affect the running job.
        req0_up  = 1'($urandom);
        req0_len = LEN_W'($urandom);
        req1_up  = 1'($urandom);
        req1_len = LEN_W'($urandom);
        @(negedge clk);
        chk("acc_busy", busy, 1);
        chk("acc_grant", grant, sel);
        chk("acc_ready0", rdy0, 0);
        chk("acc_ready1", rdy1, 0);
        if (len == 0) begin
            chk("len0_state", state, DONE);
            chk("len0_done", done, 1);
            chk("len0_done_id", done_id, sel);
            chk("len0_q", q, m_q);
        end else begin
            chk("run_state", state, RUN);
            chk("run_done", done, 0);
            chk("run_q0", q, m_q);
            for (int k = 1; k <= len; k++) begin
                if (k == hold_at) begin
                    hold = 1'b1;
                    repeat (hold_n) begin
                        @(negedge clk);
                        chk("hold_q", q, m_q);
                        chk("hold_done", done, 0);
                    end
                    hold = 1'b0;
                end
                @(negedge clk);
                m_q = mod_step(m_q, up);
                chk("step_q", q, m_q);
                chk("step_done", done, (k == len) ? 1 : 0);
                chk("step_ready0", rdy0, 0);
                chk("step_ready1", rdy1, 0);
            end
            chk("done_id", done_id, sel);
        end
        // Hold has no effect in DONE.
        hold = 1'($urandom);
        @(negedge clk);
        hold = 1'b0;
        chk("end_state", state, IDLE);
        chk("end_busy", busy, 0);
        chk("end_done", done, 0);
        chk("end_q", q, m_q);
        m_rr = 1 - sel;
    endtask

    initial begin
        do_reset(3);

        // Basic up job from reset: 1,2,3.
        do_job(1, 1, 3, 0, 0, 0, 0, 0);
        // Move to 4, then wrap up through N-1 and down through 0.
        do_job(1, 1, 1, 0, 0, 0, 0, 0);
        do_job(1, 1, 4, 0, 0, 0, 0, 0);
        do_job(1, 0, 3, 0, 0, 0, 0, 0);

        // Both requesters continuously valid: grants alternate from 0.
        do_reset(2);
        repeat (4) do_job(1, 1, 1, 1, 0, 1, 0, 0);

        // Zero-length job.
        do_job(0, 0, 0, 1, 1, 0, 0, 0);

        // Hold mid-job and on the final RUN cycle.
        do_job(1, 1, 3, 0, 0, 0, 2, 2);
        do_job(0, 0, 0, 1, 0, 3, 3, 2);

        // Reset in the second RUN cycle of a req1 job.
        do_job(1, 1, 2, 0, 0, 0, 0, 0);
        req0_valid = 1'b1;
        req0_up    = 1'b1;
        req0_len   = LEN_W'(5);
        req1_valid = 1'b1;
        req1_up    = 1'b1;
        req1_len   = LEN_W'(3);
        #1;
        chk("mid_ready0", rdy0, 0);
        chk("mid_ready1", rdy1, 1);
        @(negedge clk);
        chk("mid_run1_state", state, RUN);
        chk("mid_run1_grant", grant, 1);
        @(negedge clk);
        chk("mid_run2_q", q, mod_step(m_q, 1'b1));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready0", rdy0, 0);
        chk("mid_rst_ready1", rdy1, 0);
        rst = 1'b0;
        m_q  = 0;
        m_rr = 0;
        chk("mid_rst_q", q, 0);
        chk("mid_rst_state", state, IDLE);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_grant", grant, 0);
        // rr_ptr cleared: tie goes to req0, then pending req1 is served.
        do_job(1, 0, 1, 1, 1, 3, 0, 0);
        do_job(0, 0, 0, 1, 1, 3, 0, 0);

        // Random jobs.
        for (int i = 0; i < 30; i++) begin
            bit v0;
            bit v1;
            int l0;
            int l1;
            int hl;
            int hat;
            v0  = 1'($urandom_range(0, 1));
            v1  = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            l0  = $urandom_range(0, 7);
            l1  = $urandom_range(0, 7);
            hl  = (v0 && v1) ? ((m_rr == 1) ? l1 : l0) : (v1 ? l1 : l0);
            hat = $urandom_range(0, hl);
            do_job(v0, 1'($urandom), l0, v1, 1'($urandom), l1, hat, $urandom_range(1, 2));
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_n_job_scheduler.md
# mod_n_job_scheduler

Two-requester scheduler that shares a single mod-N up/down counter resource. Each requester submits a job: a direction and a step count. Jobs are granted round-robin and executed one step per clock on the shared counter. A one-cycle completion pulse reports the finishing requester. The block sits between client logic and the counting datapath, and is the only agent allowed to step the counter.

## Interface
Parameters:
- WIDTH, 3, counter width; requires 2 <= N <= 2**WIDTH
- N, 6, counter modulus; count range 0..N-1
- LEN_W, 4, width of job step-count field

Ports:
- i_clk  in  1  single clock; all state changes on its rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_req0_valid  in  1  requester 0 has a job pending
- i_req0_up  in  1  requester 0 direction: 1 = increment, 0 = decrement
- i_req0_len  in  LEN_W  requester 0 step count
- o_req0_ready  out  1  requester 0 job accepted this cycle when valid & ready
- i_req1_valid, i_req1_up, i_req1_len, o_req1_ready: same as above, for requester 1
- i_hold  in  1  stall; freezes stepping while high
- o_Q  out  WIDTH  shared counter value
- o_busy  out  1  high in RUN and DONE
- o_grant_id  out  1  owner of the current or last job
- o_done  out  1  one-cycle job-complete pulse
- o_done_id  out  1  requester whose job completed; valid when o_done=1

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, arbitration:
  - Neither valid: stay in IDLE.
  - Only one valid: that requester is selected.
  - Both valid: the requester equal to rr_ptr is selected.
- IDLE, handshake:
  - o_reqX_ready is combinational and high only for the selected requester in IDLE. Both ready signals are 0 in RUN and DONE.
  - On accept, latch dir, remaining = len and o_grant_id.
  - If len != 0, go to RUN. If len == 0, go straight to DONE with o_Q unchanged.
- RUN, each edge with i_hold = 0:
  - Step o_Q one position in dir.
  - Decrement remaining.
  - When remaining == 1 before the edge, go to DONE.
- RUN with i_hold = 1: o_Q and remaining hold.
- DONE:
  - o_done = 1 and o_done_id = grant id for exactly one cycle.
  - rr_ptr <= ~grant id.
  - Go to IDLE unconditionally. i_hold is ignored in DONE.
- Wrap rules:
  - Up from N-1 goes to 0; otherwise +1.
  - Down from 0 goes to N-1; otherwise -1.
  - o_Q never leaves 0..N-1.
- The counter holds its value between jobs. Only i_rst clears it.
- Request fields are sampled only at the accept edge. Changes afterwards have no effect.

## Timing
- Reset values: state = IDLE, o_Q = 0, rr_ptr = 0, remaining = 0, o_grant_id = 0, o_busy = 0, o_done = 0, o_done_id = 0.
- With i_rst high, both ready signals are 0.
- Accept at edge E0:
  - The first step is visible after E1.
  - The final value is visible after E_len.
  - o_done is high in the cycle after E_len.
  - Total latency from accept to done is len+1 cycles, plus any hold cycles.
- Back-to-back jobs: the earliest next accept is the IDLE cycle following DONE, which gives one idle-gap cycle per job.
- Reset during RUN or DONE: the job is dropped, no o_done pulse is produced, and the reset values above apply on the next edge.
- i_hold on the last RUN cycle delays both the final step and DONE until hold drops.

## Structure
- Shared package contains:
  - state encoding localparams: IDLE, RUN, DONE
  - requester-id constants
  - a clog2 helper for checking WIDTH against N
- Sub-module `mod_n_step_counter`:
  - Holds o_Q.
  - Inputs: i_clk, i_rst, i_step, i_up.
  - Owns the wrap arithmetic.
- The scheduler top holds the FSM, rr_ptr, the remaining down-counter and the handshake logic.

## Test plan
- Reset, then req0 {up=1, len=3}: o_Q goes 1,2,3. o_done with id 0 arrives 4 cycles after accept. o_Q holds at 3.
- Starting from o_Q = 4, up, len = 4: o_Q goes 5,0,1,2. Then down, len = 3: o_Q goes 1,0,5.
- Both valid continuously with len = 1:
  - grants alternate 0,1,0,1, starting with 0 after reset;
  - exactly one ready is high, and only in IDLE.
- len = 0 request: accepted, o_done the next cycle, o_Q unchanged, no RUN cycles.
- i_hold held for 2 cycles mid-job on len = 3: o_Q freezes for those 2 cycles and o_done arrives 2 cycles later than without hold.
- i_rst asserted in the second RUN cycle: next cycle o_Q = 0, state IDLE, no o_done, rr_ptr = 0, and a pending req1 is granted afterwards.
